// File: rtl/avalon_master_pkg.sv
// -----------------------------------------------------------------------------
// avalon_master_pkg
//   Definitions shared by the Avalon-MM read and write masters of soc_system.
//   - master_state_t      : IDLE / READ / DRAIN sequencing of a transfer
//   - byteenable_width()  : bytes per data word, also the address step per word
//   - BYTEENABLE_ALL_ONES : full-word byteenable for the default 32-bit data path
// -----------------------------------------------------------------------------
package avalon_master_pkg;

  // IDLE  : no transfer in progress, control_done is high
  // READ  : still issuing requests
  // DRAIN : every request issued, waiting for the outstanding responses
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } master_state_t;

  // Number of byte lanes in a data word; a word-sized address step in bytes.
  function automatic int byteenable_width(input int data_width);
    return data_width / 8;
  endfunction

  localparam int DEFAULT_DATAWIDTH       = 32;
  localparam int DEFAULT_BYTEENABLEWIDTH = DEFAULT_DATAWIDTH / 8;

  // Both masters only ever move whole words.
  localparam logic [DEFAULT_BYTEENABLEWIDTH-1:0] BYTEENABLE_ALL_ONES = '1;

endpackage : avalon_master_pkg

// File: rtl/read_master_fifo.sv
// -----------------------------------------------------------------------------
// read_master_fifo
//   Synchronous show-ahead FIFO: rd_data always holds the head word while
//   empty is low, so a consumer pops and uses the data in the same cycle.
//   Storage is an inferred RAM (registered read); the head is held in a
//   separate output register that is refilled either from the RAM entry
//   behind the head or, when the FIFO is (about to be) empty, straight from
//   the incoming write data.
//
// Ports
//   clk      in   clock, all state on the rising edge
//   reset    in   synchronous active-high; flushes the FIFO, rd_data -> 0
//   wr_en    in   push wr_data (ignored when full unless a pop coincides)
//   wr_data  in   WIDTH   word to push
//   rd_en    in   pop the head word (ignored when empty)
//   rd_data  out  WIDTH   head word, valid while empty is low
//   empty    out  no words stored
//   used     out  DEPTH_LOG2+1  number of words stored
// -----------------------------------------------------------------------------
module read_master_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   used
);

  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic [WIDTH-1:0]      head_reg;

  logic                  do_push;
  logic                  do_pop;
  logic [DEPTH_LOG2-1:0] rd_ptr_inc;

  assign do_pop     = rd_en && (count_reg != '0);
  // A pop in the same cycle frees the slot, so a push at full is still safe.
  assign do_push    = wr_en && ((count_reg != FULL_COUNT) || do_pop);
  assign rd_ptr_inc = rd_ptr_reg + PTR_ONE;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_next = rd_ptr_inc;
    end
    if (do_push && !do_pop) begin
      count_next = count_reg + ONE_COUNT;
    end else if (do_pop && !do_push) begin
      count_next = count_reg - ONE_COUNT;
    end
  end

  // RAM write port; contents need no reset because count_reg guards them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      // With two or more words stored the successor is already in RAM and
      // is never the slot being written this cycle (that would need
      // count == 1). Otherwise the incoming word becomes the new head.
      if (do_pop && (count_reg > ONE_COUNT)) begin
        head_reg <= mem[rd_ptr_inc];
      end else if (do_push && ((count_reg == '0) || do_pop)) begin
        head_reg <= wr_data;
      end
    end
  end

  assign rd_data = head_reg;
  assign empty   = (count_reg == '0);
  assign used    = count_reg;

endmodule : read_master_fifo

// File: rtl/avalon_read_master.sv
// -----------------------------------------------------------------------------
// avalon_read_master
//   Avalon-MM read master: fetches a block of words (incrementing or fixed
//   address) from HPS SDRAM into a show-ahead FIFO for FPGA-side consumers.
//   Reads are only issued while FIFO occupancy plus reads in flight is below
//   FIFODEPTH, so every response always has a free FIFO slot.
//
// Ports
//   clk, reset                 clock / synchronous active-high reset
//   control_fixed_location     1 = keep re-reading the same address
//   control_read_base          start byte address (low bits forced to 0)
//   control_read_length        length in bytes (sub-word bits ignored)
//   control_go                 start pulse, honoured only when idle
//   control_done               high while idle
//   user_read_buffer           pop the head word
//   user_buffer_data           head word (valid when user_data_available)
//   user_data_available        FIFO not empty
//   master_address/read/byteenable  Avalon-MM request
//   master_readdata/readdatavalid   Avalon-MM response
//   master_waitrequest         slave stall; request held stable meanwhile
// -----------------------------------------------------------------------------
module avalon_read_master
  import avalon_master_pkg::*;
#(
  parameter int DATAWIDTH       = 32,
  parameter int ADDRESSWIDTH    = 32,
  parameter int BYTEENABLEWIDTH = byteenable_width(DATAWIDTH),
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTH_LOG2  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  // control
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_read_base,
  input  logic [ADDRESSWIDTH-1:0]    control_read_length,
  input  logic                       control_go,
  output logic                       control_done,
  // user
  input  logic                       user_read_buffer,
  output logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_data_available,
  // Avalon-MM master
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_read,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  input  logic [DATAWIDTH-1:0]       master_readdata,
  input  logic                       master_readdatavalid,
  input  logic                       master_waitrequest
);

  localparam int CNT_W = FIFODEPTH_LOG2 + 1;

  // Address/length arithmetic is in whole words of BYTEENABLEWIDTH bytes.
  localparam logic [ADDRESSWIDTH-1:0] STEP      = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0] WORD_MASK = ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
  localparam logic [CNT_W:0]          CREDIT    = (CNT_W + 1)'(FIFODEPTH);

  master_state_t             state_reg, state_next;
  logic [ADDRESSWIDTH-1:0]   address_reg, address_next;
  logic [ADDRESSWIDTH-1:0]   remaining_reg, remaining_next;
  logic [CNT_W-1:0]          pending_reg, pending_next;
  logic                      fixed_reg, fixed_next;

  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_used;
  logic [DATAWIDTH-1:0]      fifo_rd_data;

  logic [CNT_W:0]            credit_sum;
  logic                      credit_ok;
  logic                      read_req;
  logic                      read_accept;
  logic                      resp_valid;
  logic [ADDRESSWIDTH-1:0]   go_len;
  logic                      go_start;

  // Words in the FIFO plus words still on their way must never exceed the
  // FIFO depth; this is what makes overflow impossible.
  assign credit_sum  = {1'b0, fifo_used} + {1'b0, pending_reg};
  assign credit_ok   = (credit_sum < CREDIT);

  assign read_req    = (state_reg == READ) && (remaining_reg != '0) && credit_ok;
  assign read_accept = read_req && !master_waitrequest;

  // A response is only meaningful while a read is outstanding; stray strobes
  // (e.g. from reads that were in flight across a reset) are dropped.
  assign resp_valid  = master_readdatavalid && (pending_reg != '0);

  assign go_len      = control_read_length & WORD_MASK;
  // A length shorter than one word completes immediately: stay idle.
  assign go_start    = control_go && (state_reg == IDLE) && (go_len != '0);

  always_comb begin
    state_next     = state_reg;
    address_next   = address_reg;
    remaining_next = remaining_reg;
    fixed_next     = fixed_reg;
    pending_next   = pending_reg + CNT_W'(read_accept) - CNT_W'(resp_valid);

    unique case (state_reg)
      IDLE: begin
        if (go_start) begin
          state_next     = READ;
          address_next   = control_read_base & WORD_MASK;
          remaining_next = go_len;
          fixed_next     = control_fixed_location;
        end
      end

      READ: begin
        if (read_accept) begin
          remaining_next = remaining_reg - STEP;
          // Incrementing address wraps modulo 2^ADDRESSWIDTH by width.
          if (!fixed_reg) begin
            address_next = address_reg + STEP;
          end
          if (remaining_reg == STEP) begin
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Last response this cycle -> done is visible next cycle.
        if (pending_next == '0) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      address_reg   <= '0;
      remaining_reg <= '0;
      pending_reg   <= '0;
      fixed_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      address_reg   <= address_next;
      remaining_reg <= remaining_next;
      pending_reg   <= pending_next;
      fixed_reg     <= fixed_next;
    end
  end

  read_master_fifo #(
    .WIDTH      (DATAWIDTH),
    .DEPTH      (FIFODEPTH),
    .DEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (resp_valid),
    .wr_data (master_readdata),
    .rd_en   (user_read_buffer),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .used    (fifo_used)
  );

  assign control_done        = (state_reg == IDLE);
  assign master_read         = read_req;
  assign master_address      = address_reg;
  assign master_byteenable   = '1;
  assign user_data_available = !fifo_empty;
  assign user_buffer_data    = fifo_rd_data;

endmodule : avalon_read_master
